// File: rtl/sal_ref_scheduler.sv
// Periodic DRAM refresh scheduler: tREFI ticks, refresh debt, tRFC busy window.
// Optional pull-in refresh credit is enabled by defining SAL_REF_PULLIN_EN.
module sal_ref_scheduler #(
  parameter int TREFI_W   = 16,
  parameter int TRFC_W    = 10,
  parameter int MAX_DEBT  = 8,
  parameter int URGENT_TH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_ref_en_i,
  input  logic [TREFI_W-1:0] cfg_trefi_i,
  input  logic [TRFC_W-1:0]  cfg_trfc_i,
  input  logic               idle_i,
  input  logic               ref_gnt_i,
  output logic               ref_req_o,
  output logic               ref_urgent_o,
  output logic               busy_o,
  output logic [3:0]         ref_debt_o,
  output logic               err_o
);

  localparam logic [3:0] MAX_D = 4'(MAX_DEBT);
  localparam logic [3:0] URG_D = 4'(URGENT_TH);

  typedef enum logic {
    S_IDLE,
    S_RFC
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TREFI_W-1:0] r_ivl_cnt;
  logic [TRFC_W-1:0]  r_rfc_cnt;
  logic [3:0]         r_debt;
  logic               r_urgent;
  logic               r_err;

  logic [TREFI_W-1:0] w_ivl_load;
  logic [TRFC_W-1:0]  w_rfc_load;
  logic               w_ivl_run;
  logic               w_tick;
  logic               w_req;
  logic               w_busy;
  logic               w_grant;
  logic               w_dgnt;
  logic               w_absorb;
  logic               w_inc;
  logic               w_dec;
  logic               w_ovf;
  logic [3:0]         w_credit;
  logic               w_pull_ok;
  logic [3:0]         w_debt_nxt;

  assign w_ivl_load = cfg_trefi_i - TREFI_W'(1);
  assign w_rfc_load = (cfg_trfc_i == '0) ? '0 : cfg_trfc_i - TRFC_W'(1);
  assign w_ivl_run  = cfg_ref_en_i & (cfg_trefi_i != '0);
  assign w_tick     = w_ivl_run & (r_ivl_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || !w_ivl_run || w_tick) begin
      r_ivl_cnt <= w_ivl_load;
    end else begin
      r_ivl_cnt <= r_ivl_cnt - TREFI_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_busy      = 1'b0;
    w_grant     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_req = (r_debt != '0) | w_pull_ok;
        if (w_req && ref_gnt_i) begin
          w_grant     = 1'b1;
          w_state_nxt = S_RFC;
        end
      end
      S_RFC: begin
        w_busy = 1'b1;
        if (r_rfc_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rfc_cnt <= '0;
    end else if (w_grant) begin
      r_rfc_cnt <= w_rfc_load;
    end else if (r_state == S_RFC && r_rfc_cnt != '0) begin
      r_rfc_cnt <= r_rfc_cnt - TRFC_W'(1);
    end
  end

  // A grant with debt == 0 can only be a pull-in; it never lowers debt.
  assign w_dgnt   = w_grant & (r_debt != '0);
  assign w_absorb = w_tick & (w_credit != '0);
  assign w_inc    = w_tick & ~w_absorb;
  assign w_dec    = w_dgnt & ~w_inc;
  assign w_ovf    = w_inc & ~w_grant & (r_debt == MAX_D);

  always_comb begin
    w_debt_nxt = r_debt;
    if (w_inc && !w_grant && r_debt != MAX_D) begin
      w_debt_nxt = r_debt + 4'd1;
    end else if (w_dec) begin
      w_debt_nxt = r_debt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_debt   <= '0;
      r_urgent <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_debt   <= w_debt_nxt;
      r_urgent <= (w_state_nxt == S_IDLE) & (w_debt_nxt >= URG_D);
      r_err    <= r_err | w_ovf;
    end
  end

`ifdef SAL_REF_PULLIN_EN
  logic [3:0] r_credit;
  logic       w_pgnt;
  logic       w_cr_up;
  logic       w_cr_dn;

  // Tick coinciding with a pull-in grant cancels out in both cases.
  assign w_pgnt    = w_grant & (r_debt == '0);
  assign w_cr_up   = w_pgnt & ~w_tick;
  assign w_cr_dn   = w_absorb & ~w_pgnt;
  assign w_credit  = r_credit;
  assign w_pull_ok = (r_debt == '0) & idle_i & (r_credit < MAX_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= '0;
    end else if (w_cr_up) begin
      r_credit <= r_credit + 4'd1;
    end else if (w_cr_dn) begin
      r_credit <= r_credit - 4'd1;
    end
  end
`else
  assign w_credit  = '0;
  assign w_pull_ok = 1'b0 & idle_i;
`endif

  assign ref_req_o    = w_req;
  assign ref_urgent_o = r_urgent;
  assign busy_o       = w_busy;
  assign ref_debt_o   = r_debt;
  assign err_o        = r_err;

endmodule

// File: tb/tb_sal_ref_scheduler.sv
// Scoreboard bench for sal_ref_scheduler: directed scenarios push cycle-stamped
// expected outputs, a negedge monitor pops and compares them.
module tb_sal_ref_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] trefi;
  logic [9:0]  trfc;
  logic        idle;
  logic        gnt;
  logic        gnt_r;
  logic        tie;
  logic        req;
  logic        urg;
  logic        busy;
  logic [3:0]  debt;
  logic        err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         c;
    logic [7:0] v;
    string      n;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign gnt = tie ? req : gnt_r;

  sal_ref_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_ref_en_i (en),
    .cfg_trefi_i  (trefi),
    .cfg_trfc_i   (trfc),
    .idle_i       (idle),
    .ref_gnt_i    (gnt),
    .ref_req_o    (req),
    .ref_urgent_o (urg),
    .busy_o       (busy),
    .ref_debt_o   (debt),
    .err_o        (err)
  );

  function automatic logic [7:0] mk(bit r, bit u, bit b, int d, bit e);
    return {e, 4'(d), b, u, r};
  endfunction

  task automatic push(int c, logic [7:0] v, string n);
    exp_t it;
    it.c = c;
    it.v = v;
    it.n = n;
    q.push_back(it);
  endtask

  task automatic wait_to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(output int r);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    r = cyc;
    push(r, mk(0, 0, 0, 0, 0), "reset");
  endtask

  always @(negedge clk) begin
    logic [7:0] act;
    exp_t it;
    act = {err, debt, busy, urg, req};
    while (q.size() > 0 && q[0].c <= cyc) begin
      it = q.pop_front();
      checks++;
      if (it.c < cyc) begin
        errors++;
        $display("FAIL %s missed cycle %0d", it.n, it.c);
      end else if (act !== it.v) begin
        errors++;
        $display("FAIL %s cyc %0d got {err,debt,busy,urg,req}=%b_%h_%b%b%b want %b_%h_%b%b%b",
                 it.n, cyc, act[7], act[6:3], act[2], act[1], act[0],
                 it.v[7], it.v[6:3], it.v[2], it.v[1], it.v[0]);
      end
    end
  end

  initial begin
    int r;
    int d;
    rst   = 1'b1;
    en    = 1'b1;
    trefi = 16'd100;
    trfc  = 10'd10;
    idle  = 1'b0;
    gnt_r = 1'b0;
    tie   = 1'b1;
    @(posedge clk);
    #1;

    // T1: periodic refresh, grant tied to request
    do_reset(r);
    push(r + 99,  mk(0, 0, 0, 0, 0), "T1 pre");
    push(r + 100, mk(1, 0, 0, 1, 0), "T1 req");
    push(r + 101, mk(0, 0, 1, 0, 0), "T1 busy0");
    push(r + 110, mk(0, 0, 1, 0, 0), "T1 busy9");
    push(r + 111, mk(0, 0, 0, 0, 0), "T1 done");
    push(r + 199, mk(0, 0, 0, 0, 0), "T1 pre2");
    push(r + 200, mk(1, 0, 0, 1, 0), "T1 req2");
    push(r + 201, mk(0, 0, 1, 0, 0), "T1 busy2");
    wait_to(r + 205);

    // T2: no grants, debt saturates, overflow sets err
    tie   = 1'b0;
    trefi = 16'd20;
    do_reset(r);
    for (int k = 1; k <= 9; k++) begin
      d = (k > 8) ? 8 : k;
      push(r + 20 * k - 1, mk(k > 1, (k - 1) >= 6, 0, k - 1, 0), "T2 pre");
      push(r + 20 * k, mk(1, d >= 6, 0, d, k == 9), "T2 tick");
    end
    push(r + 181, mk(1, 1, 0, 8, 1), "T2 sticky");
    wait_to(r + 185);

    // T3: tick and grant coincide at debt 3; grants in RFC ignored
    trfc = 10'd4;
    do_reset(r);
    push(r + 79, mk(1, 0, 0, 3, 0), "T3 pre");
    wait_to(r + 79);
    gnt_r = 1'b1;
    wait_to(r + 80);
    gnt_r = 1'b0;
    push(r + 80, mk(0, 0, 1, 3, 0), "T3 coinc");
    push(r + 83, mk(0, 0, 1, 3, 0), "T3 busy3");
    push(r + 84, mk(1, 0, 0, 3, 0), "T3 idle");
    push(r + 85, mk(1, 0, 0, 3, 0), "T3 ignored");
    push(r + 86, mk(0, 0, 1, 2, 0), "T3 grant");
    wait_to(r + 81);
    gnt_r = 1'b1;
    wait_to(r + 83);
    gnt_r = 1'b0;
    wait_to(r + 85);
    gnt_r = 1'b1;
    wait_to(r + 86);
    gnt_r = 1'b0;
    wait_to(r + 90);

    // T4: enable dropped mid-RFC, restart gives a full interval
    tie   = 1'b1;
    trefi = 16'd30;
    trfc  = 10'd8;
    do_reset(r);
    push(r + 30,  mk(1, 0, 0, 1, 0), "T4 req");
    push(r + 31,  mk(0, 0, 1, 0, 0), "T4 busy");
    push(r + 38,  mk(0, 0, 1, 0, 0), "T4 busy7");
    push(r + 39,  mk(0, 0, 0, 0, 0), "T4 rfc end");
    push(r + 100, mk(0, 0, 0, 0, 0), "T4 disabled");
    push(r + 129, mk(0, 0, 0, 0, 0), "T4 re pre");
    push(r + 130, mk(1, 0, 0, 1, 0), "T4 re tick");
    push(r + 131, mk(0, 0, 1, 0, 0), "T4 re busy");
    wait_to(r + 33);
    en = 1'b0;
    wait_to(r + 100);
    en = 1'b1;
    wait_to(r + 135);

    // T5: reset while in RFC with debt 5
    tie   = 1'b0;
    trefi = 16'd10;
    trfc  = 10'd20;
    do_reset(r);
    push(r + 60, mk(1, 1, 0, 6, 0), "T5 urgent");
    push(r + 61, mk(0, 0, 1, 5, 0), "T5 rfc");
    push(r + 64, mk(0, 0, 1, 5, 0), "T5 pre rst");
    wait_to(r + 60);
    gnt_r = 1'b1;
    wait_to(r + 61);
    gnt_r = 1'b0;
    wait_to(r + 64);
    do_reset(r);
    push(r + 9,  mk(0, 0, 0, 0, 0), "T5 reload");
    push(r + 10, mk(1, 0, 0, 1, 0), "T5 tick");
    wait_to(r + 12);

`ifdef SAL_REF_PULLIN_EN
    // T6: eight pull-ins, eight absorbed ticks, ninth tick requests
    tie   = 1'b1;
    idle  = 1'b1;
    trefi = 16'd1000;
    trfc  = 10'd10;
    do_reset(r);
    push(r + 1,    mk(0, 0, 1, 0, 0), "T6 pull0");
    push(r + 11,   mk(1, 0, 0, 0, 0), "T6 req1");
    push(r + 78,   mk(0, 0, 1, 0, 0), "T6 pull7");
    push(r + 88,   mk(0, 0, 0, 0, 0), "T6 full");
    push(r + 1000, mk(0, 0, 0, 0, 0), "T6 abs1");
    push(r + 8000, mk(0, 0, 0, 0, 0), "T6 abs8");
    push(r + 8999, mk(0, 0, 0, 0, 0), "T6 pre9");
    push(r + 9000, mk(1, 0, 0, 1, 0), "T6 tick9");
    push(r + 9001, mk(0, 0, 1, 0, 0), "T6 busy9");
    wait_to(r + 88);
    idle = 1'b0;
    wait_to(r + 9005);
`else
    // T6: idle_i has no effect without pull-in support
    tie   = 1'b1;
    idle  = 1'b1;
    trefi = 16'd50;
    do_reset(r);
    push(r + 1,  mk(0, 0, 0, 0, 0), "T6 no pull");
    push(r + 49, mk(0, 0, 0, 0, 0), "T6 pre");
    push(r + 50, mk(1, 0, 0, 1, 0), "T6 tick");
    wait_to(r + 55);
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    while (q.size() > 0) begin
      exp_t it;
      it = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s pending at cycle %0d (due %0d)", it.n, cyc, it.c);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
